// File: rtl/oct_cmd_pkg.sv
// Shared definitions for the UART command path: frame constants, parser
// state encoding and the command codes understood by the DDS control logic.
package oct_cmd_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN      = 7;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_CHK  = 2'd3
  } parser_state_t;

  localparam logic [7:0] CMD_SET_FREQ  = 8'h01;
  localparam logic [7:0] CMD_SET_PHASE = 8'h02;
  localparam logic [7:0] CMD_SET_AMPL  = 8'h03;
  localparam logic [7:0] CMD_DDS_RESET = 8'h10;

endpackage

// File: rtl/byte_gap_timer.sv
// Counts idle cycles between received bytes; expired flags the last allowed
// idle cycle, and is suppressed when a byte arrives in that same cycle.
module byte_gap_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] count;

  assign expired = enable && !clear && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames HEADER,CMD,D3..D0,CHK byte streams into commands with an XOR check,
// reporting checksum, timeout and overrun errors as one-cycle pulses.
module uart_cmd_parser
  import oct_cmd_pkg::*;
#(
  parameter logic [7:0] HEADER      = HEADER_DEFAULT,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [7:0]    cmd_code,
  output logic [31:0]   cmd_data,
  output logic          err_chk,
  output logic          err_timeout,
  output logic          err_overrun,
  output logic          busy,
  output parser_state_t dbg_state
);

  // Handshake: cmd_valid rises with a loaded command and holds it, with
  // cmd_code/cmd_data stable, until a cycle where cmd_valid && cmd_ready.
  parser_state_t state;
  logic [1:0]    data_idx;
  logic [7:0]    shadow_code;
  logic [31:0]   shadow_data;
  logic [7:0]    xor_acc;
  logic          gap_expired;
  logic          good_frame;

  assign busy      = (state != ST_HUNT);
  assign dbg_state = state;

  // The running XOR folded with CHK is zero exactly when the checksum matches.
  assign good_frame = (state == ST_CHK) && rx_valid && ((xor_acc ^ rx_data) == 8'h00);

  byte_gap_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_gap_timer (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .clear   (rx_valid),
    .enable  (busy),
    .expired (gap_expired)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ST_HUNT;
      data_idx    <= 2'd0;
      shadow_code <= 8'h00;
      shadow_data <= 32'h0;
      xor_acc     <= 8'h00;
      cmd_valid   <= 1'b0;
      cmd_code    <= 8'h00;
      cmd_data    <= 32'h0;
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;

      if (good_frame) begin
        if (!cmd_valid || cmd_ready) begin
          cmd_valid <= 1'b1;
          cmd_code  <= shadow_code;
          cmd_data  <= shadow_data;
        end else begin
          err_overrun <= 1'b1;
        end
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end

      if (gap_expired) begin
        state       <= ST_HUNT;
        err_timeout <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          ST_HUNT: begin
            if (rx_data == HEADER) state <= ST_CMD;
          end
          ST_CMD: begin
            shadow_code <= rx_data;
            xor_acc     <= rx_data;
            data_idx    <= 2'd0;
            state       <= ST_DATA;
          end
          ST_DATA: begin
            shadow_data <= {shadow_data[23:0], rx_data};
            xor_acc     <= xor_acc ^ rx_data;
            data_idx    <= data_idx + 2'd1;
            if (data_idx == 2'd3) state <= ST_CHK;
          end
          ST_CHK: begin
            if (!good_frame) err_chk <= 1'b1;
            state <= ST_HUNT;
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-stream command framer between the UART receiver and the DDS control logic inside `top`. It consumes single-cycle `rx_valid` byte strobes and hunts for a fixed 7-byte frame. It verifies an XOR checksum and presents each good frame as one command (8-bit code, 32-bit data) on a valid/ready handshake. Inter-byte timeouts, checksum failures and overruns are reported as one-cycle error pulses; the parser then re-hunts.

## Interface
Parameters:
- `HEADER`, 8'hA5, frame start byte.
- `TIMEOUT_CYC`, 50000, max sys_clk cycles between bytes inside a frame (1 ms at 50 MHz; one byte at 115200 baud is about 4340 cycles).

Ports (one clock; reset is synchronous and active-high):
- `sys_clk` in 1: system clock, 50 MHz.
- `sys_rst` in 1: synchronous active-high reset.
- `rx_data` in 8: received byte, valid only while `rx_valid` is high.
- `rx_valid` in 1: one-cycle strobe per received byte.
- `cmd_valid` out 1: command available; held until accepted.
- `cmd_ready` in 1: consumer accepts the command when `cmd_valid && cmd_ready`.
- `cmd_code` out 8: command byte.
- `cmd_data` out 32: payload, first payload byte in [31:24].
- `err_chk` out 1: one-cycle pulse on checksum mismatch.
- `err_timeout` out 1: one-cycle pulse on inter-byte timeout.
- `err_overrun` out 1: one-cycle pulse when a good frame is dropped.
- `busy` out 1: high in every state except HUNT.

## Operation
- Frame format: `HEADER`, CMD, D3, D2, D1, D0, CHK.
- Checksum rule: CHK = CMD ^ D3 ^ D2 ^ D1 ^ D0. `HEADER` is excluded.
- State machine: HUNT -> CMD -> DATA (2-bit index 0..3) -> CHK -> HUNT. Transitions happen only on `rx_valid`, except for timeout.
- HUNT: bytes other than `HEADER` are discarded silently. `HEADER` moves the parser to CMD.
- A byte equal to `HEADER` received mid-frame is treated as ordinary data. There is no resync.
- CMD: latch the byte into the shadow code register and seed the running XOR with it.
- DATA: shift bytes MSB-first into the shadow data register and fold each into the XOR. After index 3, go to CHK.
- CHK, match: the frame is good, go to HUNT.
- CHK, mismatch: pulse `err_chk`, go to HUNT, produce no output.
- Good frame while the output is empty, or while `cmd_ready` is high that same cycle: load the shadow registers into `cmd_code`/`cmd_data` and set `cmd_valid`.
- Good frame while `cmd_valid && !cmd_ready`: keep the old command, drop the new one, pulse `err_overrun`.
- Timeout: a gap counter clears on every `rx_valid`. In any state other than HUNT, reaching `TIMEOUT_CYC-1` without a byte pulses `err_timeout` and returns the parser to HUNT. The counter is frozen in HUNT.
- `rx_valid` in the same cycle the counter expires: the byte wins and no timeout is raised.
- `cmd_valid` clears on handshake unless a new good frame loads in that same cycle; in that case it stays high with the new values.

## Timing
- Reset values: all outputs 0, state HUNT, counter 0, shadow registers 0.
- Reset mid-frame: the partial frame and any pending command are discarded. No error pulse is generated.
- Latency: `cmd_valid` rises on the first sys_clk edge after the cycle in which CHK arrives with `rx_valid` (registered, one cycle).
- Error pulses are registered, exactly one cycle wide, and asserted one cycle after the causing event.
- `cmd_code`/`cmd_data` stay stable while `cmd_valid && !cmd_ready`.
- Back-to-back frames with zero idle time are accepted at full byte rate.

## Structure
- Shared package/include `oct_cmd_pkg`: `HEADER` default, frame length (7), state encodings, command-code constants used by the DDS control logic.
- One natural sub-module, `byte_gap_timer`: clear/enable inputs and an `expired` output, sized by `$clog2(TIMEOUT_CYC)`.
- The framing state machine, XOR accumulator and output register stay in `uart_cmd_parser`. Target size is about 200 lines.

## Test plan
- A5 01 12 34 56 78 09 with `cmd_ready`=1 -> one-cycle `cmd_valid`, `cmd_code`=8'h01, `cmd_data`=32'h12345678, no error pulse.
- Same frame with CHK=8'h0A -> `err_chk` pulse, `cmd_valid` stays 0, and a following good frame is accepted.
- Leading garbage 00 FF 5A, then a good frame -> garbage ignored, exactly one command out.
- A5 01 12, then silence for `TIMEOUT_CYC`+10 cycles -> single `err_timeout` pulse, `busy` drops, and the next frame parses correctly.
- `cmd_ready`=0, then two good frames -> first command held, `err_overrun` pulse on the second, and `cmd_data` still shows the first payload.
- `sys_rst` asserted after the third byte of a frame -> all outputs 0, HUNT state, and the next frame decodes correctly.
